// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-master SDRAM Wishbone arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / GNT_CPU / GNT_DMA)
//   - owner_e     : encoding of the last master that held the grant
//   - GRANT_*     : one-hot grant_o encodings (bit0 CPU, bit1 DMA)
//   - BURST_CNT_W : width of the per-grant ack counter
//   - grant_of()  : decode of a state into its grant_o value
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GNT_CPU = 2'b01,
    ST_GNT_DMA = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [1:0] GRANT_IDLE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;

  // One-hot owner for a given arbiter state; anything unknown reads as idle.
  function automatic logic [1:0] grant_of(input arb_state_e st);
    logic [1:0] g;
    case (st)
      ST_GNT_CPU: g = GRANT_CPU;
      ST_GNT_DMA: g = GRANT_DMA;
      default:    g = GRANT_IDLE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sdram_arb_timer.sv
// -----------------------------------------------------------------------------
// sdram_arb_timer
// Stall watchdog for the arbiter's current grant. Counts cycles in which the
// owning master strobes without an SDRAM ack; 'expire' is raised during the
// TIMEOUT_CYCLES-th consecutive stalled cycle so the arbiter can abort the
// grant at that same edge. Only instantiated when SDRAM_ARB_TIMEOUT_EN is set.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-low reset
//   stall  in  1  owner stb=1 and no ack this cycle
//   clear  in  1  ack seen, grant changing, or no grant held
//   expire out 1  stall limit reached in this cycle
// -----------------------------------------------------------------------------
module sdram_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic clear,
  output logic expire
);

  // Counter only needs to hold 0..TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Expiry is flagged while the last allowed stalled cycle is in progress.
  always_comb begin
    expire = 1'b0;
    if (stall && (cnt_r == CNT_LIMIT)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Stall cycle counter; expiry restarts it because the grant is abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || expire) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (stall) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Two-master (CPU, DMA) Wishbone arbiter in front of a single SDRAM slave.
// Round-robin on simultaneous requests from IDLE, one-cycle grant latency,
// forced re-arbitration after BURST_MAX acks when the other master waits.
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN -- enables a stall watchdog
// (sdram_arb_timer) that aborts a grant after TIMEOUT_CYCLES un-acked strobe
// cycles and pulses the owner's err_o. Without it, err outputs are tied 0.
// Ports:
//   clk, rst                      clock, async active-low reset
//   cpu_{stb,cyc,we,sel,dat,adr}_i CPU Wishbone request
//   cpu_{ack,dat,err}_o           CPU ack / read data / timeout error
//   dma_*                         same set for the DMA master
//   srm_{stb,cyc,we,sel,dat,adr}_o SDRAM slave request (from current owner)
//   srm_{ack,dat}_i               SDRAM ack / read data
//   grant_o                       one-hot owner: 01 CPU, 10 DMA, 00 idle
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_MAX      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stb_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [31:0] cpu_adr_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_err_o,
  input  logic        dma_stb_i,
  input  logic        dma_cyc_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_sel_i,
  input  logic [31:0] dma_dat_i,
  input  logic [31:0] dma_adr_i,
  output logic        dma_ack_o,
  output logic [31:0] dma_dat_o,
  output logic        dma_err_o,
  output logic        srm_stb_o,
  output logic        srm_cyc_o,
  output logic        srm_we_o,
  output logic [3:0]  srm_sel_o,
  output logic [31:0] srm_dat_o,
  output logic [31:0] srm_adr_o,
  input  logic        srm_ack_i,
  input  logic [31:0] srm_dat_i,
  output logic [1:0]  grant_o
);

  // Elaboration-time guards on the parameter ranges.
  if ((BURST_MAX < 1) || (BURST_MAX > 255)) begin : g_burst_max_range
    $error("sdram_arbiter: BURST_MAX must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("sdram_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(BURST_MAX);
  localparam logic [BURST_CNT_W-1:0] BURST_ONE   = BURST_CNT_W'(1);

  arb_state_e             state_r;
  arb_state_e             state_next_s;
  owner_e                 last_owner_r;
  owner_e                 last_owner_next_s;
  logic [BURST_CNT_W-1:0] burst_cnt_r;
  logic [BURST_CNT_W-1:0] burst_cnt_next_s;
  logic                   cpu_req_s;
  logic                   dma_req_s;
  logic                   burst_done_s;
  logic                   timeout_hit_s;

  assign cpu_req_s = cpu_cyc_i & cpu_stb_i;
  assign dma_req_s = dma_cyc_i & dma_stb_i;

  // This ack completes the burst allowance; the count wraps to zero here.
  assign burst_done_s = srm_ack_i && ((burst_cnt_r + BURST_ONE) == BURST_LIMIT);

  // Next-state selection: round-robin from IDLE, release/abort/burst hand-off
  // from a grant state. A timed-out owner counts as having released the bus.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req_s && dma_req_s) begin
          state_next_s = (last_owner_r == OWN_DMA) ? ST_GNT_CPU : ST_GNT_DMA;
        end else if (cpu_req_s) begin
          state_next_s = ST_GNT_CPU;
        end else if (dma_req_s) begin
          state_next_s = ST_GNT_DMA;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GNT_CPU: begin
        if (!cpu_cyc_i || timeout_hit_s) begin
          state_next_s = dma_req_s ? ST_GNT_DMA : ST_IDLE;
        end else if (burst_done_s && dma_req_s) begin
          state_next_s = ST_GNT_DMA;
        end else begin
          state_next_s = ST_GNT_CPU;
        end
      end
      ST_GNT_DMA: begin
        if (!dma_cyc_i || timeout_hit_s) begin
          state_next_s = cpu_req_s ? ST_GNT_CPU : ST_IDLE;
        end else if (burst_done_s && cpu_req_s) begin
          state_next_s = ST_GNT_CPU;
        end else begin
          state_next_s = ST_GNT_DMA;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Burst counter and round-robin history follow the chosen next state.
  always_comb begin
    burst_cnt_next_s  = burst_cnt_r;
    last_owner_next_s = last_owner_r;
    if (state_next_s != state_r) begin
      burst_cnt_next_s = {BURST_CNT_W{1'b0}};
      if (state_next_s == ST_GNT_CPU) begin
        last_owner_next_s = OWN_CPU;
      end else if (state_next_s == ST_GNT_DMA) begin
        last_owner_next_s = OWN_DMA;
      end else begin
        last_owner_next_s = last_owner_r;
      end
    end else if ((state_r != ST_IDLE) && srm_ack_i) begin
      // Reaching the limit with nobody waiting keeps the grant, restarts count.
      burst_cnt_next_s = burst_done_s ? {BURST_CNT_W{1'b0}} : (burst_cnt_r + BURST_ONE);
    end else begin
      burst_cnt_next_s = burst_cnt_r;
    end
  end

  // Arbiter state, burst count and last owner registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      last_owner_r <= OWN_DMA;
      burst_cnt_r  <= {BURST_CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      last_owner_r <= last_owner_next_s;
      burst_cnt_r  <= burst_cnt_next_s;
    end
  end

  // Slave request mux and ack/data return, steered by the registered owner
  // only, so the non-owner never reaches the slave nor sees an ack.
  always_comb begin
    srm_stb_o = 1'b0;
    srm_cyc_o = 1'b0;
    srm_we_o  = 1'b0;
    srm_sel_o = 4'h0;
    srm_dat_o = 32'h0000_0000;
    srm_adr_o = 32'h0000_0000;
    cpu_ack_o = 1'b0;
    cpu_dat_o = 32'h0000_0000;
    dma_ack_o = 1'b0;
    dma_dat_o = 32'h0000_0000;
    case (state_r)
      ST_GNT_CPU: begin
        srm_stb_o = cpu_stb_i;
        srm_cyc_o = cpu_cyc_i;
        srm_we_o  = cpu_we_i;
        srm_sel_o = cpu_sel_i;
        srm_dat_o = cpu_dat_i;
        srm_adr_o = cpu_adr_i;
        cpu_ack_o = srm_ack_i;
        cpu_dat_o = srm_dat_i;
      end
      ST_GNT_DMA: begin
        srm_stb_o = dma_stb_i;
        srm_cyc_o = dma_cyc_i;
        srm_we_o  = dma_we_i;
        srm_sel_o = dma_sel_i;
        srm_dat_o = dma_dat_i;
        srm_adr_o = dma_adr_i;
        dma_ack_o = srm_ack_i;
        dma_dat_o = srm_dat_i;
      end
      default: begin
        srm_stb_o = 1'b0;
      end
    endcase
  end

  assign grant_o = grant_of(state_r);

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic owner_stb_s;
  logic tmr_stall_s;
  logic tmr_clear_s;

  // Watchdog inputs: stall only while the owner strobes un-acked; restart on
  // any ack, any grant change, or while idle.
  always_comb begin
    owner_stb_s = 1'b0;
    case (state_r)
      ST_GNT_CPU: owner_stb_s = cpu_stb_i;
      ST_GNT_DMA: owner_stb_s = dma_stb_i;
      default:    owner_stb_s = 1'b0;
    endcase
    tmr_stall_s = owner_stb_s & ~srm_ack_i;
    tmr_clear_s = srm_ack_i | (state_next_s != state_r) | (state_r == ST_IDLE);
  end

  sdram_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .stall  (tmr_stall_s),
    .clear  (tmr_clear_s),
    .expire (timeout_hit_s)
  );

  // Error pulse goes to whoever owned the bus when the watchdog fired.
  assign cpu_err_o = timeout_hit_s & (state_r == ST_GNT_CPU);
  assign dma_err_o = timeout_hit_s & (state_r == ST_GNT_DMA);
`else
  assign timeout_hit_s = 1'b0;
  assign cpu_err_o     = 1'b0;
  assign dma_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed scenarios plus a randomized phase. Every cycle the stimulus side
// pushes the reference model's expected outputs into a queue; a monitor on
// the falling edge pops and compares. Directed constants are also checked
// inline. Honors SDRAM_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int BM = 8;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_stb_i, cpu_cyc_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_dat_i, cpu_adr_i;
  logic        cpu_ack_o, cpu_err_o;
  logic [31:0] cpu_dat_o;
  logic        dma_stb_i, dma_cyc_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_dat_i, dma_adr_i;
  logic        dma_ack_o, dma_err_o;
  logic [31:0] dma_dat_o;
  logic        srm_stb_o, srm_cyc_o, srm_we_o;
  logic [3:0]  srm_sel_o;
  logic [31:0] srm_dat_o, srm_adr_o;
  logic        srm_ack_i;
  logic [31:0] srm_dat_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  sdram_arbiter #(.BURST_MAX(BM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_stb_i(cpu_stb_i), .cpu_cyc_i(cpu_cyc_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_dat_i(cpu_dat_i), .cpu_adr_i(cpu_adr_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o), .cpu_err_o(cpu_err_o),
    .dma_stb_i(dma_stb_i), .dma_cyc_i(dma_cyc_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_dat_i(dma_dat_i), .dma_adr_i(dma_adr_i),
    .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o), .dma_err_o(dma_err_o),
    .srm_stb_o(srm_stb_o), .srm_cyc_o(srm_cyc_o), .srm_we_o(srm_we_o),
    .srm_sel_o(srm_sel_o), .srm_dat_o(srm_dat_o), .srm_adr_o(srm_adr_o),
    .srm_ack_i(srm_ack_i), .srm_dat_i(srm_dat_i), .grant_o(grant_o)
  );

  typedef struct {
    logic [1:0]  grant;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat, adr;
    logic        cack, cerr, dack, derr;
    logic [31:0] cdat, ddat;
    int          bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: owner 0 none / 1 CPU / 2 DMA; last = last granted master.
  int owner, last, bcnt, tmo;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    owner = 0; last = 2; bcnt = 0; tmo = 0;
  endtask

  task automatic drive_idle();
    cpu_stb_i = 1'b0; cpu_cyc_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
    cpu_dat_i = 32'h0; cpu_adr_i = 32'h0;
    dma_stb_i = 1'b0; dma_cyc_i = 1'b0; dma_we_i = 1'b0; dma_sel_i = 4'h0;
    dma_dat_i = 32'h0; dma_adr_i = 32'h0;
    srm_ack_i = 1'b0; srm_dat_i = 32'h0;
  endtask

  // Record expected outputs for the current cycle, advance the model by the
  // arbitration rules, then move to 1 ns after the next rising edge.
  task automatic step();
    exp_t e;
    bit creq, dreq, ack, hit, own_cyc, own_stb, oth_req;
    int nxt, oth;
    creq = cpu_cyc_i & cpu_stb_i;
    dreq = dma_cyc_i & dma_stb_i;
    ack  = srm_ack_i;
    e.grant = 2'b00; e.stb = 1'b0; e.cyc = 1'b0; e.we = 1'b0; e.sel = 4'h0;
    e.dat = 32'h0; e.adr = 32'h0; e.cack = 1'b0; e.dack = 1'b0;
    e.cdat = 32'h0; e.ddat = 32'h0; e.cerr = 1'b0; e.derr = 1'b0;
    own_cyc = 1'b0; own_stb = 1'b0;
    if (owner == 1) begin
      e.grant = 2'b01; e.stb = cpu_stb_i; e.cyc = cpu_cyc_i; e.we = cpu_we_i;
      e.sel = cpu_sel_i; e.dat = cpu_dat_i; e.adr = cpu_adr_i;
      e.cack = ack; e.cdat = srm_dat_i;
      own_cyc = cpu_cyc_i; own_stb = cpu_stb_i;
    end else if (owner == 2) begin
      e.grant = 2'b10; e.stb = dma_stb_i; e.cyc = dma_cyc_i; e.we = dma_we_i;
      e.sel = dma_sel_i; e.dat = dma_dat_i; e.adr = dma_adr_i;
      e.dack = ack; e.ddat = srm_dat_i;
      own_cyc = dma_cyc_i; own_stb = dma_stb_i;
    end
    hit = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    hit = (owner != 0) && own_stb && !ack && (tmo == TO - 1);
`endif
    e.cerr = hit && (owner == 1);
    e.derr = hit && (owner == 2);
    e.bcnt = bcnt;
    exp_q.push_back(e);

    if (owner == 0) begin
      if (creq && dreq) nxt = (last == 2) ? 1 : 2;
      else if (creq)    nxt = 1;
      else if (dreq)    nxt = 2;
      else              nxt = 0;
    end else begin
      oth = 3 - owner;
      oth_req = (oth == 1) ? creq : dreq;
      if (!own_cyc || hit)                         nxt = oth_req ? oth : 0;
      else if (ack && (bcnt + 1 == BM) && oth_req) nxt = oth;
      else                                         nxt = owner;
    end
    if (nxt != owner) begin
      bcnt = 0; tmo = 0;
      if (nxt != 0) last = nxt;
    end else if (owner != 0 && ack) begin
      bcnt = (bcnt + 1) % BM;
      tmo = 0;
    end else if (owner != 0 && own_stb) begin
      tmo = tmo + 1;
    end
    owner = nxt;
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after a rising edge with nothing queued.
  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_srm_cyc", srm_cyc_o, 1'b0);
    chk("rst_srm_stb", srm_stb_o, 1'b0);
    chk("rst_cpu_ack", cpu_ack_o, 1'b0);
    chk("rst_dma_ack", dma_ack_o, 1'b0);
    chk("rst_cpu_err", cpu_err_o, 1'b0);
    chk("rst_dma_err", dma_err_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant_o", grant_o, e.grant);
      chk("srm_stb_o", srm_stb_o, e.stb);
      chk("srm_cyc_o", srm_cyc_o, e.cyc);
      chk("srm_we_o", srm_we_o, e.we);
      chk("srm_sel_o", srm_sel_o, e.sel);
      chk("srm_dat_o", srm_dat_o, e.dat);
      chk("srm_adr_o", srm_adr_o, e.adr);
      chk("cpu_ack_o", cpu_ack_o, e.cack);
      chk("cpu_dat_o", cpu_dat_o, e.cdat);
      chk("cpu_err_o", cpu_err_o, e.cerr);
      chk("dma_ack_o", dma_ack_o, e.dack);
      chk("dma_dat_o", dma_dat_o, e.ddat);
      chk("dma_err_o", dma_err_o, e.derr);
      chk("burst_cnt", dut.burst_cnt_r, e.bcnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit c_cyc, d_cyc;
    rst = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // CPU-only read answered with DEADBEEF.
    repeat (2) step();
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
    cpu_adr_i = 32'h3800_0000;
    #1 chk("a_req_cycle_grant", grant_o, 2'b00);
    step();
    srm_ack_i = 1'b1; srm_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("a_grant", grant_o, 2'b01);
    chk("a_adr", srm_adr_o, 32'h3800_0000);
    chk("a_cpu_dat", cpu_dat_o, 32'hDEAD_BEEF);
    chk("a_cpu_ack", cpu_ack_o, 1'b1);
    chk("a_dma_ack", dma_ack_o, 1'b0);
    step();
    drive_idle();
    repeat (2) step();

    // Simultaneous request after reset: CPU first, DMA after CPU drops cyc.
    do_reset();
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_adr_i = 32'h0000_1000;
    dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_adr_i = 32'h0000_2000;
    step();
    srm_ack_i = 1'b1;
    #1 chk("b_cpu_first", grant_o, 2'b01);
    repeat (3) step();
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; srm_ack_i = 1'b0;
    step();
    #1 chk("b_dma_next", grant_o, 2'b10);
    drive_idle();
    repeat (2) step();

    // DMA burst pre-empted by a waiting CPU on the 8th ack, then re-granted.
    do_reset();
    dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_we_i = 1'b1; dma_sel_i = 4'hF;
    step();
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    for (int k = 1; k <= BM; k++) begin
      srm_ack_i = 1'b1; srm_dat_i = 32'(k);
      #1;
      chk("c_dma_hold", grant_o, 2'b10);
      chk("c_cpu_no_ack", cpu_ack_o, 1'b0);
      step();
    end
    #1 chk("c_switch_on_8th", grant_o, 2'b01);
    repeat (3) step();
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; srm_ack_i = 1'b0;
    step();
    #1 chk("c_dma_regrant", grant_o, 2'b10);
    srm_ack_i = 1'b1;
    repeat (20 - BM) step();
    drive_idle();
    repeat (2) step();

    // DMA alone, 20 acks: grant held, burst count wraps.
    do_reset();
    dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_adr_i = 32'h0000_4000;
    step();
    for (int k = 0; k < 20; k++) begin
      srm_ack_i = 1'b1; srm_dat_i = $urandom;
      #1 chk("d_grant_held", grant_o, 2'b10);
      step();
    end
    drive_idle();
    repeat (2) step();

    // CPU strobes and the slave never answers.
    do_reset();
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_adr_i = 32'h0000_8000;
    step();
`ifdef SDRAM_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      #1 chk("e_err_pulse", cpu_err_o, (k == TO) ? 1'b1 : 1'b0);
      step();
    end
    #1 chk("e_after_timeout_grant", grant_o, 2'b00);
`else
    for (int k = 0; k < 100; k++) begin
      #1;
      chk("e_grant_held", grant_o, 2'b01);
      chk("e_no_err", cpu_err_o, 1'b0);
      step();
    end
`endif
    drive_idle();
    repeat (2) step();

    // Reset asserted in the middle of a DMA write.
    do_reset();
    dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_we_i = 1'b1; dma_sel_i = 4'h3;
    dma_dat_i = 32'h1234_5678; dma_adr_i = 32'h0000_C000;
    step();
    srm_ack_i = 1'b1;
    #1;
    chk("f_pre_grant", grant_o, 2'b10);
    chk("f_pre_cyc", srm_cyc_o, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("f_async_cyc", srm_cyc_o, 1'b0);
    chk("f_async_grant", grant_o, 2'b00);
    chk("f_async_ack", dma_ack_o, 1'b0);
    chk("f_async_we", srm_we_o, 1'b0);
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Randomized traffic against the model.
    c_cyc = 1'b0; d_cyc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) c_cyc = ~c_cyc;
      if ($urandom_range(7) == 0) d_cyc = ~d_cyc;
      cpu_cyc_i = c_cyc;
      cpu_stb_i = c_cyc ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
      cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom);
      cpu_dat_i = $urandom; cpu_adr_i = $urandom;
      dma_cyc_i = d_cyc;
      dma_stb_i = d_cyc ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
      dma_we_i = 1'($urandom); dma_sel_i = 4'($urandom);
      dma_dat_i = $urandom; dma_adr_i = $urandom;
      srm_ack_i = 1'($urandom); srm_dat_i = $urandom;
      step();
    end

    drive_idle();
    repeat (2) step();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 8: max acks per grant before forced re-arbitration (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles without ack before abort (used only with SDRAM_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_stb_i, cpu_cyc_i, cpu_we_i  in  1 each  CPU Wishbone strobe/cycle/write-enable.
REQ-006 SHALL have ports cpu_sel_i  in  4, cpu_dat_i  in  32, cpu_adr_i  in  32  CPU byte-select/write data/address.
REQ-007 SHALL have ports cpu_ack_o  out  1, cpu_dat_o  out  32, cpu_err_o  out  1  CPU ack/read data/timeout error.
REQ-008 SHALL have dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_dat_i, dma_adr_i, dma_ack_o, dma_dat_o, dma_err_o with the same directions and widths as the CPU set: DMA Wishbone master.
REQ-009 SHALL have ports srm_stb_o, srm_cyc_o, srm_we_o  out  1; srm_sel_o  out  4; srm_dat_o, srm_adr_o  out  32  SDRAM slave request.
REQ-010 SHALL have ports srm_ack_i  in  1, srm_dat_i  in  32  SDRAM ack/read data.
REQ-011 SHALL have port grant_o  out  2  one-hot owner: bit0 CPU, bit1 DMA, 00 idle.

Function
REQ-012 SHALL implement FSM states IDLE, GNT_CPU, GNT_DMA; grant_o is decoded from the registered state.
REQ-013 SHALL treat a master as requesting when its cyc_i=1 and stb_i=1.
REQ-014 In IDLE, SHALL move to the requesting master's grant state on the next edge; grant latency is 1 cycle.
REQ-015 If both masters request in IDLE, SHALL grant the master not recorded in register last_owner (round-robin).
REQ-016 In GNT_x, SHALL drive all srm_* outputs combinationally from master x; in IDLE, srm_* SHALL be 0.
REQ-017 SHALL route srm_ack_i and srm_dat_i to the owner only; the non-owner sees ack 0 and dat 0 in the same cycle.
REQ-018 SHALL count acks in an 8-bit burst_cnt; burst_cnt clears on every grant change.
REQ-019 When owner cyc_i=0, SHALL go to the other grant state if the other master requests, else to IDLE.
REQ-020 When an ack makes burst_cnt equal BURST_MAX and the other master requests, SHALL switch directly to the other grant state at that edge.
REQ-021 When burst_cnt reaches BURST_MAX and the other master is not requesting, SHALL keep the grant and clear burst_cnt.
REQ-022 SHALL update last_owner on every transition into a grant state.
REQ-023 The non-owner's stb/cyc SHALL never reach srm_*; no ack is ever delivered to both masters.

Reset
REQ-024 On rst=0, SHALL asynchronously set state IDLE, last_owner=DMA (CPU wins the first tie), burst_cnt=0, timeout counter=0.
REQ-025 During reset, all outputs SHALL be 0; grant_o=00.
REQ-026 A reset asserted mid-grant SHALL drop srm_cyc_o immediately, and no ack SHALL be forwarded.

Configuration
REQ-027 With SDRAM_ARB_TIMEOUT_EN defined, SHALL count cycles in a grant state with owner stb=1 and srm_ack_i=0, clearing the count on ack or grant change.
REQ-028 When that count reaches TIMEOUT_CYCLES, SHALL pulse the owner's err_o for 1 cycle and leave the grant as REQ-019 dictates with the owner treated as not requesting, forcing a switch or IDLE.
REQ-029 Without SDRAM_ARB_TIMEOUT_EN, no timeout counter SHALL exist and cpu_err_o, dma_err_o SHALL be tied 0.

Structure
REQ-030 SHALL take state encoding, grant encoding and the burst_cnt width constant from shared package sdram_arb_pkg.
REQ-031 SHALL place the timeout counter in sub-module sdram_arb_timer, instantiated only under SDRAM_ARB_TIMEOUT_EN.

Verification
REQ-032 Bench SHALL cover: CPU-only read of adr 0x3800_0000, slave acks with 0xDEAD_BEEF -> grant_o=01 one cycle after request; cpu_dat_o=0xDEAD_BEEF; dma_ack_o stays 0.
REQ-033 Bench SHALL cover: CPU and DMA request in the same cycle after reset -> CPU granted first; DMA granted after CPU drops cyc.
REQ-034 Bench SHALL cover: DMA holds cyc for 20 acks while CPU requests, BURST_MAX=8 -> grant switches to CPU on the edge of the 8th DMA ack; DMA is re-granted when CPU releases.
REQ-035 Bench SHALL cover: DMA alone holds cyc for 20 acks -> grant_o stays 10 throughout and burst_cnt wraps at 8.
REQ-036 Bench SHALL cover: with SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, slave never acks CPU -> cpu_err_o pulses on the 64th cycle, then grant goes to IDLE or DMA; without the macro, grant is held indefinitely.
REQ-037 Bench SHALL cover: rst pulled low mid DMA write -> srm_cyc_o=0 and grant_o=00 without waiting for a clock edge.
